pipe_arbiter: RTL and testbench

Round-robin scheduler that shares the single `pipeline` datapath (D = A*B + C, 8-bit operands, 16-bit result, fixed latency) between two requesters. Accepts operand triples over valid/ready, drives the pipeline inputs, tracks every in-flight operation with an owner tag, and returns each result to the requester that issued it. Sits directly in front of `pipeline` in the top-level, one per shared datapath instance.

---
 rtl/pipe_arb_pkg.sv | 13 +
 rtl/pipe_tag_sr.sv | 30 +++
 rtl/pipe_arbiter.sv | 101 ++++++++++
 tb/tb_pipe_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_arb_pkg.sv
// rtl/pipe_arb_pkg.sv - shared types and constants for the pipeline arbiter
package pipe_arb_pkg;

  localparam int N_REQ = 2;

  typedef logic [0:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/pipe_tag_sr.sv
// rtl/pipe_tag_sr.sv - owner-tag shift register that follows operations through the pipeline
module pipe_tag_sr
  import pipe_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t sr [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr[i] <= '0;
      end
    end else begin
      sr[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign tag_out = sr[DEPTH-1];

endmodule

// File: rtl/pipe_arbiter.sv
// rtl/pipe_arbiter.sv - round-robin sharing of one D = A*B + C pipeline between two requesters
module pipe_arbiter
  import pipe_arb_pkg::*;
#(
  parameter  int PIPE_LAT = 3,
  localparam int CNT_W    = $clog2(PIPE_LAT + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  logic [7:0]       req_A0,
  input  logic [7:0]       req_B0,
  input  logic [7:0]       req_C0,
  input  logic [7:0]       req_A1,
  input  logic [7:0]       req_B1,
  input  logic [7:0]       req_C1,
  output logic [7:0]       pipe_A,
  output logic [7:0]       pipe_B,
  output logic [7:0]       pipe_C,
  input  logic [15:0]      pipe_D,
  output logic [N_REQ-1:0] resp_valid,
  output logic [15:0]      resp_D,
  output logic             busy,
  output logic [CNT_W-1:0] inflight
);

  logic             last_grant;
  logic [N_REQ-1:0] grant;
  logic             accept;
  req_id_t          acc_id;
  tag_t             tag_in;
  tag_t             tag_out;

  // Requester 0 wins a tie unless it was the last one served; nothing is granted in reset.
  always_comb begin
    grant = '0;
    if (rst) begin
      if (req_valid[0] && (!req_valid[1] || last_grant)) begin
        grant[0] = 1'b1;
      end else if (req_valid[1]) begin
        grant[1] = 1'b1;
      end
    end
  end

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign acc_id    = grant[1];

  assign tag_in.valid = accept;
  assign tag_in.id    = acc_id;

  pipe_tag_sr #(
    .DEPTH (PIPE_LAT + 1)
  ) u_tag_sr (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_A     <= '0;
      pipe_B     <= '0;
      pipe_C     <= '0;
      last_grant <= 1'b1;
      resp_valid <= '0;
      resp_D     <= '0;
      inflight   <= '0;
    end else begin
      if (accept) begin
        pipe_A     <= acc_id[0] ? req_A1 : req_A0;
        pipe_B     <= acc_id[0] ? req_B1 : req_B0;
        pipe_C     <= acc_id[0] ? req_C1 : req_C0;
        last_grant <= acc_id[0];
      end else begin
        pipe_A <= '0;
        pipe_B <= '0;
        pipe_C <= '0;
      end

      resp_valid <= '0;
      if (tag_out.valid) begin
        resp_valid[tag_out.id] <= 1'b1;
        resp_D                 <= pipe_D;
      end

      // Issue and retire on the same edge cancel out.
      case ({accept, tag_out.valid})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign busy = (inflight != '0);

endmodule

// File: tb/tb_pipe_arbiter.sv
// tb/tb_pipe_arbiter.sv - directed and random scoreboard bench for pipe_arbiter
module tb_pipe_arbiter;
  import pipe_arb_pkg::*;

  localparam int PIPE_LAT = 3;
  localparam int L        = PIPE_LAT + 1;
  localparam int CW       = $clog2(PIPE_LAT + 2);

  logic          clk;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [7:0]    req_A0, req_B0, req_C0, req_A1, req_B1, req_C1;
  logic [7:0]    pipe_A, pipe_B, pipe_C;
  logic [15:0]   pipe_D;
  logic [1:0]    resp_valid;
  logic [15:0]   resp_D;
  logic          busy;
  logic [CW-1:0] inflight;

  pipe_arbiter #(.PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_A0(req_A0), .req_B0(req_B0), .req_C0(req_C0),
    .req_A1(req_A1), .req_B1(req_B1), .req_C1(req_C1),
    .pipe_A(pipe_A), .pipe_B(pipe_B), .pipe_C(pipe_C), .pipe_D(pipe_D),
    .resp_valid(resp_valid), .resp_D(resp_D), .busy(busy), .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural pipeline: PIPE_LAT register stages computing A*B + C.
  logic [15:0] pl [PIPE_LAT];
  always @(posedge clk) begin
    pl[0] <= 16'(pipe_A) * 16'(pipe_B) + 16'(pipe_C);
    for (int i = 1; i < PIPE_LAT; i++) pl[i] <= pl[i-1];
  end
  assign pipe_D = pl[PIPE_LAT-1];

  typedef struct {
    logic [0:0]  id;
    logic [15:0] d;
    int          edge_n;
  } exp_t;

  exp_t sbq[$];
  int   gq[$];
  int   total, bad, cyc, pulses0, pulses1, peak;
  exp_t e;
  logic [1:0] acc;

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return 16'(a) * 16'(b) + 16'(c);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: push expectations at accept, pop and compare at each response strobe.
  always @(negedge clk) begin
    if (rst) begin
      check("ready_onehot", 32'($countones(req_ready) <= 1), 1);
      check("resp_onehot", 32'($countones(resp_valid) <= 1), 1);
      acc = req_valid & req_ready;
      if (acc[0]) begin
        sbq.push_back('{1'b0, model(req_A0, req_B0, req_C0), cyc + 1});
        gq.push_back(0);
      end
      if (acc[1]) begin
        sbq.push_back('{1'b1, model(req_A1, req_B1, req_C1), cyc + 1});
        gq.push_back(1);
      end
      if (int'(inflight) > peak) peak = int'(inflight);
      if (resp_valid != 2'b00) begin
        if (resp_valid[0]) pulses0++;
        if (resp_valid[1]) pulses1++;
        if (sbq.size() == 0) begin
          check("unexpected_resp", 32'(resp_valid), 0);
        end else begin
          e = sbq.pop_front();
          check("resp_id", 32'(resp_valid), 32'(2'b01 << e.id));
          check("resp_data", 32'(resp_D), 32'(e.d));
          check("resp_latency", cyc, e.edge_n + L);
        end
      end
    end
  end

  task automatic drive(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] c0,
                       input logic [7:0] a1, input logic [7:0] b1, input logic [7:0] c1);
    req_valid = v;
    req_A0 = a0; req_B0 = b0; req_C0 = c0;
    req_A1 = a1; req_B1 = b1; req_C1 = c1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input logic [1:0] v);
    drive(v, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic apply_reset();
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    sbq.delete();
    gq.delete();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sbq.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(n < 50), 1);
    check("idle_busy", 32'(busy), 0);
    check("idle_inflight", 32'(inflight), 0);
  endtask

  int exp_mixed [6] = '{1, 1, 1, 0, 1, 0};
  int pat [5]       = '{1, 1, 0, 0, 1};
  int psum;

  initial begin
    total = 0; bad = 0; cyc = 0; pulses0 = 0; pulses1 = 0; peak = 0;
    rst = 1'b0;
    drive(2'b11, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
    #1;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_pipe_A", 32'(pipe_A), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_D", 32'(resp_D), 0);
    check("rst_inflight", 32'(inflight), 0);
    check("rst_busy", 32'(busy), 0);
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Single request from requester 0.
    drive(2'b01, 8'h3F, 8'h3F, 8'h03, 0, 0, 0);
    tick();
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    check("single_pipe_A", 32'(pipe_A), 32'h3F);
    check("single_pipe_B", 32'(pipe_B), 32'h3F);
    check("single_pipe_C", 32'(pipe_C), 32'h03);
    check("single_inflight", 32'(inflight), 1);
    check("single_busy", 32'(busy), 1);
    wait_idle();
    check("single_resp_D", 32'(resp_D), 32'h0F84);
    check("single_pulses0", pulses0, 1);
    check("single_pulses1", pulses1, 0);

    // Continuous contention from a fresh reset.
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive_rand(2'b11);
      tick();
    end
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    wait_idle();
    check("contend_count", gq.size(), 6);
    for (int i = 0; i < 6 && i < gq.size(); i++) check("contend_grant", gq[i], i % 2);

    // Mixed traffic: requester 1 alone, then both.
    gq.delete();
    peak = 0;
    for (int i = 0; i < 3; i++) begin drive_rand(2'b10); tick(); end
    for (int i = 0; i < 3; i++) begin drive_rand(2'b11); tick(); end
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    wait_idle();
    check("mixed_count", gq.size(), 6);
    for (int i = 0; i < 6 && i < gq.size(); i++) check("mixed_grant", gq[i], exp_mixed[i]);
    check("mixed_peak", peak, L);
    check("mixed_busy", 32'(busy), 0);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin drive_rand(2'b01); tick(); end
    check("mid_inflight", 32'(inflight), 3);
    drive(2'b11, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC);
    #2;
    rst = 1'b0;
    #1;
    check("mid_pipe_A", 32'(pipe_A), 0);
    check("mid_pipe_B", 32'(pipe_B), 0);
    check("mid_pipe_C", 32'(pipe_C), 0);
    check("mid_resp_valid", 32'(resp_valid), 0);
    check("mid_resp_D", 32'(resp_D), 0);
    check("mid_inflight0", 32'(inflight), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_ready", 32'(req_ready), 0);
    sbq.delete();
    psum = pulses0 + pulses1;
    tick();
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    repeat (10) tick();
    check("mid_no_pulse", pulses0 + pulses1, psum);
    drive(2'b01, 8'h10, 8'h10, 8'h01, 0, 0, 0);
    tick();
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    wait_idle();
    check("mid_new_resp", pulses0 + pulses1, psum + 1);
    check("mid_new_D", 32'(resp_D), 32'h0101);

    // Idle gaps between accepts.
    psum = pulses0 + pulses1;
    for (int i = 0; i < 5; i++) begin
      if (pat[i] != 0) drive(2'b01, 8'(i + 1), 8'(i + 2), 8'(i + 3), 0, 0, 0);
      else drive(2'b00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF);
      tick();
      check("gap_pipe_A", 32'(pipe_A), (pat[i] != 0) ? 32'(i + 1) : 0);
      check("gap_pipe_B", 32'(pipe_B), (pat[i] != 0) ? 32'(i + 2) : 0);
      check("gap_pipe_C", 32'(pipe_C), (pat[i] != 0) ? 32'(i + 3) : 0);
    end
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    wait_idle();
    check("gap_pulses", pulses0 + pulses1, psum + 3);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      drive_rand(2'($urandom_range(0, 3)));
      tick();
    end
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    wait_idle();
    check("final_sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
